// File: rtl/dataram_access_sched_if.sv
// Request/grant, RAM command and read-response bundle of the data RAM access scheduler.
// master = requester side (MSHR/pipeline and RAM consumer), slave = the scheduler.
interface dataram_access_sched_if #(
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned ADDR_W   = 10
);
    localparam int unsigned BankW = $clog2(NUM_BANK);

    logic                rxdat_wr_vld;
    logic [BankW-1:0]    rxdat_wr_bank;
    logic [ADDR_W-1:0]   rxdat_wr_addr;
    logic                rxdat_wr_rdy;

    logic                evict_rd_vld;
    logic [BankW-1:0]    evict_rd_bank;
    logic [ADDR_W-1:0]   evict_rd_addr;
    logic                evict_rd_rdy;

    logic                dataram_wr_vld;
    logic [BankW-1:0]    dataram_wr_bank;
    logic [ADDR_W-1:0]   dataram_wr_addr;
    logic                dataram_wr_rdy;

    logic                dataram_rd_vld;
    logic [BankW-1:0]    dataram_rd_bank;
    logic [ADDR_W-1:0]   dataram_rd_addr;
    logic                dataram_rd_rdy;

    logic                ram_en;
    logic                ram_wr;
    logic [BankW-1:0]    ram_bank;
    logic [ADDR_W-1:0]   ram_addr;
    logic [1:0]          ram_src;
    logic                rd_rsp_vld;
    logic [1:0]          rd_rsp_src;
    logic [NUM_BANK-1:0] bank_busy;

    modport master (
        output rxdat_wr_vld, rxdat_wr_bank, rxdat_wr_addr,
        output evict_rd_vld, evict_rd_bank, evict_rd_addr,
        output dataram_wr_vld, dataram_wr_bank, dataram_wr_addr,
        output dataram_rd_vld, dataram_rd_bank, dataram_rd_addr,
        input  rxdat_wr_rdy, evict_rd_rdy, dataram_wr_rdy, dataram_rd_rdy,
        input  ram_en, ram_wr, ram_bank, ram_addr, ram_src,
        input  rd_rsp_vld, rd_rsp_src, bank_busy
    );

    modport slave (
        input  rxdat_wr_vld, rxdat_wr_bank, rxdat_wr_addr,
        input  evict_rd_vld, evict_rd_bank, evict_rd_addr,
        input  dataram_wr_vld, dataram_wr_bank, dataram_wr_addr,
        input  dataram_rd_vld, dataram_rd_bank, dataram_rd_addr,
        output rxdat_wr_rdy, evict_rd_rdy, dataram_wr_rdy, dataram_rd_rdy,
        output ram_en, ram_wr, ram_bank, ram_addr, ram_src,
        output rd_rsp_vld, rd_rsp_src, bank_busy
    );
endinterface

// File: rtl/dataram_access_sched.sv
// Data RAM access scheduler: one command per cycle to a free bank, fixed priority with
// starvation promotion, and read-latency tracking that tags each response with its source.
module dataram_access_sched #(
    parameter int unsigned NUM_BANK      = 4,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned BANK_BUSY_CYC = 2,
    parameter int unsigned STARVE_TH     = 8,
    parameter int unsigned RD_LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dataram_access_sched_if.slave bus_io
);
    localparam int unsigned NumReq = 4;
    localparam int unsigned BankW  = $clog2(NUM_BANK);
    localparam int unsigned WaitW  = $clog2(STARVE_TH + 1);
    localparam int unsigned BusyW  = (BANK_BUSY_CYC > 1) ? $clog2(BANK_BUSY_CYC) : 1;

    logic [NumReq-1:0] req_vld;
    logic [BankW-1:0]  req_bank [NumReq];
    logic [ADDR_W-1:0] req_addr [NumReq];

    logic [BusyW-1:0]    busy_cnt_q [NUM_BANK];
    logic [BusyW-1:0]    busy_cnt_d [NUM_BANK];
    logic [NUM_BANK-1:0] bank_busy;
    logic [WaitW-1:0]    wait_q [NumReq];
    logic [WaitW-1:0]    wait_d [NumReq];

    logic [NumReq-1:0] elig;
    logic [NumReq-1:0] starved;
    logic [NumReq-1:0] gnt;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [BankW-1:0]  gnt_bank;

    logic              ram_en_q;
    logic              ram_wr_q;
    logic [BankW-1:0]  ram_bank_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [1:0]        ram_src_q;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [1:0]        rd_src_q [RD_LAT];

    assign req_vld = {bus_io.dataram_rd_vld, bus_io.dataram_wr_vld,
                      bus_io.evict_rd_vld, bus_io.rxdat_wr_vld};
    assign req_bank[0] = bus_io.rxdat_wr_bank;
    assign req_bank[1] = bus_io.evict_rd_bank;
    assign req_bank[2] = bus_io.dataram_wr_bank;
    assign req_bank[3] = bus_io.dataram_rd_bank;
    assign req_addr[0] = bus_io.rxdat_wr_addr;
    assign req_addr[1] = bus_io.evict_rd_addr;
    assign req_addr[2] = bus_io.dataram_wr_addr;
    assign req_addr[3] = bus_io.dataram_rd_addr;

    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_busy[b] = (busy_cnt_q[b] != '0);
        end
    end

    always_comb begin
        elig    = '0;
        starved = '0;
        for (int i = 0; i < NumReq; i++) begin
            elig[i]    = req_vld[i] && !bank_busy[req_bank[i]];
            starved[i] = (wait_q[i] == WaitW'(STARVE_TH));
        end
    end

    // Descending scans leave the lowest index standing; the starved pass overrides the plain one.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (elig[i]) begin
                gnt_idx = 2'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (elig[i] && starved[i]) begin
                gnt_idx = 2'(i);
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_bank = req_bank[gnt_idx];

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            wait_d[i] = '0;
            if (req_vld[i] && !gnt[i]) begin
                wait_d[i] = starved[i] ? wait_q[i] : wait_q[i] + WaitW'(1);
            end
        end
    end

    // A fresh grant reloads the counter even if it would otherwise be decrementing.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            busy_cnt_d[b] = busy_cnt_q[b];
            if (gnt_any && (gnt_bank == BankW'(b))) begin
                busy_cnt_d[b] = BusyW'(BANK_BUSY_CYC - 1);
            end else if (busy_cnt_q[b] != '0) begin
                busy_cnt_d[b] = busy_cnt_q[b] - BusyW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                busy_cnt_q[b] <= '0;
            end
            for (int i = 0; i < NumReq; i++) begin
                wait_q[i] <= '0;
            end
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_bank_q <= '0;
            ram_addr_q <= '0;
            ram_src_q  <= '0;
            rd_vld_q   <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                rd_src_q[k] <= '0;
            end
        end else begin
            busy_cnt_q <= busy_cnt_d;
            wait_q     <= wait_d;
            ram_en_q   <= gnt_any;
            if (gnt_any) begin
                ram_wr_q   <= ~gnt_idx[0];
                ram_bank_q <= gnt_bank;
                ram_addr_q <= req_addr[gnt_idx];
                ram_src_q  <= gnt_idx;
            end
            rd_vld_q[0] <= ram_en_q && !ram_wr_q;
            rd_src_q[0] <= ram_src_q;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_src_q[k] <= rd_src_q[k-1];
            end
        end
    end

    assign bus_io.rxdat_wr_rdy   = gnt[0];
    assign bus_io.evict_rd_rdy   = gnt[1];
    assign bus_io.dataram_wr_rdy = gnt[2];
    assign bus_io.dataram_rd_rdy = gnt[3];
    assign bus_io.ram_en         = ram_en_q;
    assign bus_io.ram_wr         = ram_wr_q;
    assign bus_io.ram_bank       = ram_bank_q;
    assign bus_io.ram_addr       = ram_addr_q;
    assign bus_io.ram_src        = ram_src_q;
    assign bus_io.rd_rsp_vld     = rd_vld_q[RD_LAT-1];
    assign bus_io.rd_rsp_src     = rd_src_q[RD_LAT-1];
    assign bus_io.bank_busy      = bank_busy;
endmodule

// File: tb/tb_dataram_access_sched.sv
// Randomized and directed bench for dataram_access_sched against a cycle-level reference
// model that tracks bank free times, wait lengths and due times of read responses.
module tb_dataram_access_sched;
    localparam int unsigned NB   = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned BBC  = 2;
    localparam int unsigned STH  = 8;
    localparam int unsigned RL   = 2;
    localparam int          OBSN = 4096;

    logic clk;
    logic rst_n;

    dataram_access_sched_if #(.NUM_BANK(NB), .ADDR_W(AW)) bus_if ();

    dataram_access_sched #(
        .NUM_BANK(NB), .ADDR_W(AW), .BANK_BUSY_CYC(BBC), .STARVE_TH(STH), .RD_LAT(RL)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          t_vld  [4];
    logic [1:0]    t_bank [4];
    logic [AW-1:0] t_addr [4];
    logic [3:0]    t_rdy;

    assign bus_if.rxdat_wr_vld    = t_vld[0];
    assign bus_if.rxdat_wr_bank   = t_bank[0];
    assign bus_if.rxdat_wr_addr   = t_addr[0];
    assign bus_if.evict_rd_vld    = t_vld[1];
    assign bus_if.evict_rd_bank   = t_bank[1];
    assign bus_if.evict_rd_addr   = t_addr[1];
    assign bus_if.dataram_wr_vld  = t_vld[2];
    assign bus_if.dataram_wr_bank = t_bank[2];
    assign bus_if.dataram_wr_addr = t_addr[2];
    assign bus_if.dataram_rd_vld  = t_vld[3];
    assign bus_if.dataram_rd_bank = t_bank[3];
    assign bus_if.dataram_rd_addr = t_addr[3];
    assign t_rdy = {bus_if.dataram_rd_rdy, bus_if.dataram_wr_rdy,
                    bus_if.evict_rd_rdy, bus_if.rxdat_wr_rdy};

    // Reference model state
    int            cyc;
    int            free_at [NB];
    int            waited  [4];
    int            rsp_due [$];
    int            rsp_src [$];
    logic          m_en;
    logic          m_wr;
    logic [1:0]    m_bank;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_src;

    int         obs_gnt  [OBSN];
    logic       obs_rvld [OBSN];
    logic [1:0] obs_rsrc [OBSN];
    logic [3:0] obs_busy [OBSN];

    int n_chk;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) free_at[b] = 0;
        for (int i = 0; i < 4; i++) waited[i] = 0;
        rsp_due.delete();
        rsp_src.delete();
        m_en   = 1'b0;
        m_wr   = 1'b0;
        m_bank = '0;
        m_addr = '0;
        m_src  = '0;
    endtask

    task automatic set_req(input int i, input int b, input int a);
        t_vld[i]  = 1'b1;
        t_bank[i] = 2'(b);
        t_addr[i] = AW'(a);
    endtask

    // One clock cycle: check at the falling edge, advance the model, retire granted requests.
    task automatic run_cycle();
        int         g;
        logic [3:0] exp_rdy;
        logic [3:0] exp_busy;
        logic [3:0] seen;
        bit         due;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < 4; i++)
            if (g < 0 && t_vld[i] && free_at[t_bank[i]] <= cyc && waited[i] >= int'(STH)) g = i;
        for (int i = 0; i < 4; i++)
            if (g < 0 && t_vld[i] && free_at[t_bank[i]] <= cyc) g = i;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        for (int b = 0; b < NB; b++) exp_busy[b] = (cyc < free_at[b]);
        check_eq("rdy", 32'(t_rdy), 32'(exp_rdy));
        check_eq("bank_busy", 32'(bus_if.bank_busy), 32'(exp_busy));
        check_eq("ram_en", 32'(bus_if.ram_en), 32'(m_en));
        check_eq("ram_wr", 32'(bus_if.ram_wr), 32'(m_wr));
        check_eq("ram_bank", 32'(bus_if.ram_bank), 32'(m_bank));
        check_eq("ram_addr", 32'(bus_if.ram_addr), 32'(m_addr));
        check_eq("ram_src", 32'(bus_if.ram_src), 32'(m_src));
        due = (rsp_due.size() > 0) && (rsp_due[0] == cyc);
        check_eq("rd_rsp_vld", 32'(bus_if.rd_rsp_vld), 32'(due));
        if (due) begin
            check_eq("rd_rsp_src", 32'(bus_if.rd_rsp_src), 32'(rsp_src[0]));
            void'(rsp_due.pop_front());
            void'(rsp_src.pop_front());
        end
        if (cyc < OBSN) begin
            obs_gnt[cyc] = -1;
            for (int i = 0; i < 4; i++) if (t_rdy[i]) obs_gnt[cyc] = (obs_gnt[cyc] < 0) ? i : -2;
            obs_rvld[cyc] = bus_if.rd_rsp_vld;
            obs_rsrc[cyc] = bus_if.rd_rsp_src;
            obs_busy[cyc] = bus_if.bank_busy;
        end
        for (int i = 0; i < 4; i++) begin
            if (t_vld[i] && i != g) waited[i] = (waited[i] < int'(STH)) ? waited[i] + 1 : waited[i];
            else waited[i] = 0;
        end
        m_en = (g >= 0);
        if (g >= 0) begin
            m_wr   = (g == 0 || g == 2);
            m_bank = t_bank[g];
            m_addr = t_addr[g];
            m_src  = 2'(g);
            free_at[t_bank[g]] = cyc + int'(BBC);
            if (!m_wr) begin
                rsp_due.push_back(cyc + 1 + int'(RL));
                rsp_src.push_back(g);
            end
        end
        seen = t_rdy;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) if (seen[i]) t_vld[i] = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    initial begin
        int t0;
        int rx_n;
        int first3;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_vld[i]  = 1'b0;
            t_bank[i] = '0;
            t_addr[i] = '0;
        end
        model_reset();
        #2;
        check_eq("reset_ram_en", 32'(bus_if.ram_en), 32'd0);
        check_eq("reset_ram_cmd", 32'({bus_if.ram_wr, bus_if.ram_bank, bus_if.ram_addr,
                                       bus_if.ram_src}), 32'd0);
        check_eq("reset_rsp", 32'({bus_if.rd_rsp_vld, bus_if.rd_rsp_src}), 32'd0);
        check_eq("reset_busy", 32'(bus_if.bank_busy), 32'd0);
        check_eq("reset_rdy", 32'(t_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drain(2);

        // All four requesters to distinct free banks
        t0 = cyc;
        for (int i = 0; i < 4; i++) set_req(i, i, 16 * i + 3);
        drain(8);
        for (int k = 0; k < 4; k++) check_eq("t1_gnt_order", 32'(obs_gnt[t0+k]), 32'(k));
        check_eq("t1_rsp1_vld", 32'(obs_rvld[t0+4]), 32'd1);
        check_eq("t1_rsp1_src", 32'(obs_rsrc[t0+4]), 32'd1);
        check_eq("t1_rsp_gap", 32'(obs_rvld[t0+5]), 32'd0);
        check_eq("t1_rsp3_vld", 32'(obs_rvld[t0+6]), 32'd1);
        check_eq("t1_rsp3_src", 32'(obs_rsrc[t0+6]), 32'd3);

        // Same bank contention
        t0 = cyc;
        set_req(0, 2, 5);
        set_req(3, 2, 6);
        drain(6);
        check_eq("t2_gnt0", 32'(obs_gnt[t0]), 32'd0);
        check_eq("t2_blocked", 32'(obs_gnt[t0+1]), 32'hffff_ffff);
        check_eq("t2_busy2", 32'(obs_busy[t0+1][2]), 32'd1);
        check_eq("t2_gnt3", 32'(obs_gnt[t0+2]), 32'd3);

        // Starvation promotion of the hit read
        t0   = cyc;
        rx_n = 0;
        set_req(0, 0, 100);
        set_req(3, 1, 200);
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            if (!t_vld[0]) begin
                rx_n++;
                set_req(0, rx_n % 4, 100 + rx_n);
            end
        end
        drain(6);
        first3 = -1;
        for (int k = 11; k >= 0; k--) if (obs_gnt[t0+k] == 3) first3 = k;
        check_eq("t3_starve_gnt_cycle", 32'(first3), 32'd8);

        // Busy higher-priority requester lets a lower one through
        t0 = cyc;
        set_req(1, 3, 7);
        run_cycle();
        set_req(0, 3, 8);
        set_req(2, 0, 9);
        drain(6);
        check_eq("t4_bypass_gnt", 32'(obs_gnt[t0+1]), 32'd2);

        // Back-to-back reads 1,3,1
        t0 = cyc;
        set_req(1, 0, 11);
        set_req(3, 1, 12);
        run_cycle();
        run_cycle();
        set_req(1, 2, 13);
        drain(6);
        for (int k = 0; k < 3; k++) check_eq("t5_rsp_vld", 32'(obs_rvld[t0+RL+1+k]), 32'd1);
        check_eq("t5_src_a", 32'(obs_rsrc[t0+RL+1]), 32'd1);
        check_eq("t5_src_b", 32'(obs_rsrc[t0+RL+2]), 32'd3);
        check_eq("t5_src_c", 32'(obs_rsrc[t0+RL+3]), 32'd1);
        check_eq("t5_rsp_end", 32'(obs_rvld[t0+RL+4]), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 4; i++)
                if (!t_vld[i] && $urandom_range(0, 2) == 0)
                    set_req(i, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 1023)));
            run_cycle();
        end
        drain(20);

        // Asynchronous reset with a read in flight
        set_req(3, 0, 21);
        run_cycle();
        set_req(1, 2, 22);
        run_cycle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_ram_en", 32'(bus_if.ram_en), 32'd0);
        check_eq("rst_rsp_vld", 32'(bus_if.rd_rsp_vld), 32'd0);
        check_eq("rst_busy", 32'(bus_if.bank_busy), 32'd0);
        check_eq("rst_ram_src", 32'(bus_if.ram_src), 32'd0);
        for (int i = 0; i < 4; i++) t_vld[i] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = cyc + 2;
        drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dataram_access_sched.md
Name: dataram_access_sched

Overview:
- Schedules access to the banked vector-cache data RAM among four requesters: linefill write (downstream rxdat), evict read, hit write and hit read.
- Issues at most one RAM command per cycle, to a bank that is not busy.
- Requesters are served in fixed priority, with an anti-starvation promotion.
- Tracks read latency and returns the source ID with each read response.
- Sits between the MSHR/pipeline request sources and the data RAM macro.

Parameters:
NUM_BANK, 4, number of data RAM banks (power of 2, ≥2)
ADDR_W, 10, per-bank row address width
BANK_BUSY_CYC, 2, cycles a bank is occupied per access (≥1)
STARVE_TH, 8, wait cycles before a requester is promoted (≥1)
RD_LAT, 2, cycles from ram_en (read) to RAM data valid (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rxdat_wr_vld  in  1  linefill write request (requester 0)
rxdat_wr_bank  in  $clog2(NUM_BANK)  target bank
rxdat_wr_addr  in  ADDR_W  row address
rxdat_wr_rdy  out  1  grant
evict_rd_vld / evict_rd_bank / evict_rd_addr / evict_rd_rdy  in/in/in/out  1/$clog2(NUM_BANK)/ADDR_W/1  evict read (requester 1)
dataram_wr_vld / dataram_wr_bank / dataram_wr_addr / dataram_wr_rdy  same widths  hit write (requester 2)
dataram_rd_vld / dataram_rd_bank / dataram_rd_addr / dataram_rd_rdy  same widths  hit read (requester 3)
ram_en  out  1  registered RAM command valid
ram_wr  out  1  1=write, 0=read
ram_bank  out  $clog2(NUM_BANK)  command bank
ram_addr  out  ADDR_W  command row
ram_src  out  2  granted requester ID (0..3)
rd_rsp_vld  out  1  read data valid at RAM output
rd_rsp_src  out  2  requester ID of that read
bank_busy  out  NUM_BANK  per-bank occupied flag

Behaviour:
- Reset: all outputs 0; all bank busy counters, wait counters and the read-tracking pipe are cleared.
- Reset is asynchronous: asserting it mid-operation drops in-flight commands and pending read responses with no partial output.
- Handshake: transfer occurs when vld&&rdy. Requesters hold vld and bank/addr stable until rdy. rdy is combinational from current vld, bank_busy and wait counters; it does not depend on any rdy.
- Eligibility: requester i is eligible iff vld[i] && !bank_busy[bank[i]].
- Priority: a requester is starved when wait_cnt[i]==STARVE_TH.
  - Eligible starved requesters beat eligible non-starved ones.
  - Within each class the fixed order is 0 > 1 > 2 > 3.
  - Exactly one rdy is high when any requester is eligible, otherwise none.
- Wait counters: 2-bit-index array, width $clog2(STARVE_TH+1).
  - vld && !rdy: increment, saturating at STARVE_TH.
  - rdy or !vld: clear to 0.
- Bank busy: per-bank down-counter.
  - On grant to bank b, load BANK_BUSY_CYC-1. Otherwise decrement if nonzero.
  - bank_busy[b] = (cnt[b]!=0) and is driven from the register, so it is valid the cycle after a grant.
  - With BANK_BUSY_CYC=1 a bank is never busy; back-to-back grants to the same bank are legal.
  - A grant and a decrement in the same cycle on the same bank: the load wins.
- Command: ram_en/ram_wr/ram_bank/ram_addr/ram_src are registered one cycle after the handshake. ram_wr=1 for requesters 0 and 2, 0 for requesters 1 and 3. ram_en=0 in cycles with no grant; the other command fields hold their last value.
- Read tracking: an RD_LAT-deep shift pipe of {vld,src}.
  - Loaded when ram_en && !ram_wr.
  - rd_rsp_vld/rd_rsp_src appear exactly RD_LAT cycles after that ram_en. Back-to-back reads produce back-to-back responses in issue order.
  - Writes never produce a response.
- Throughput: 1 command/cycle when consecutive grants target different free banks.

Test Plan:
- All four vld=1, banks 0/1/2/3, all free → grants in cycles 0..3 to src 0,1,2,3. ram_en rises 1 cycle after each grant, ram_wr=1,0,1,0. Responses: rd_rsp_src=1 in cycle 1+1+RD_LAT=4 and rd_rsp_src=3 in cycle 3+1+RD_LAT=6.
- rxdat_wr and dataram_rd both target bank 2, BANK_BUSY_CYC=2 → src0 granted cycle 0. bank_busy[2]=1 in cycle 1. src3 granted cycle 2.
- rxdat_wr continuously valid to rotating banks; dataram_rd held valid to bank 1, with the bank free when checked → dataram_rd promoted after 8 wait cycles and granted no later than cycle 8 ahead of rxdat_wr. Its wait_cnt returns to 0 after the grant.
- Requester targets a busy bank while a lower-priority requester targets a free bank → the lower-priority requester is granted that cycle. No rdy is asserted to the blocked requester.
- Three back-to-back reads (src 1,3,1) to banks 0,1,2 → rd_rsp_vld high for 3 consecutive cycles starting RD_LAT cycles after the first ram_en, with src sequence 1,3,1.
- rst_n asserted one cycle after a read command issues → rd_rsp_vld, ram_en, bank_busy all 0 immediately and remain 0 after release until new requests arrive.
